// File: rtl/register_file_pkg.sv
// Shared constants for the register file: PC register index, PC read
// offset and the default datapath width.
package register_file_pkg;

  // Address that maps to the program counter rather than R0-R14.
  localparam logic [3:0] PC_IDX = 4'd15;

  // Reading R15 returns the current PC plus this offset.
  localparam int PC_READ_OFFSET = 8;

  // Default data and PC width.
  localparam int DEFAULT_W = 32;

endpackage : register_file_pkg

// File: rtl/register_file_mux_16_1.sv
// W-bit 16:1 multiplexer. Select value k routes input in(k+1) to the output.
// The register file uses this for its read ports, with in16 carrying pc+8.
module mux_16_1 #(
  parameter int W = register_file_pkg::DEFAULT_W
) (
  input  logic [3:0]   i_sel,
  input  logic [W-1:0] i_in1,
  input  logic [W-1:0] i_in2,
  input  logic [W-1:0] i_in3,
  input  logic [W-1:0] i_in4,
  input  logic [W-1:0] i_in5,
  input  logic [W-1:0] i_in6,
  input  logic [W-1:0] i_in7,
  input  logic [W-1:0] i_in8,
  input  logic [W-1:0] i_in9,
  input  logic [W-1:0] i_in10,
  input  logic [W-1:0] i_in11,
  input  logic [W-1:0] i_in12,
  input  logic [W-1:0] i_in13,
  input  logic [W-1:0] i_in14,
  input  logic [W-1:0] i_in15,
  input  logic [W-1:0] i_in16,
  output logic [W-1:0] o_out
);

  // Pure combinational selection of one of the sixteen inputs.
  always_comb begin
    o_out = i_in1;
    case (i_sel)
      4'd0:  o_out = i_in1;
      4'd1:  o_out = i_in2;
      4'd2:  o_out = i_in3;
      4'd3:  o_out = i_in4;
      4'd4:  o_out = i_in5;
      4'd5:  o_out = i_in6;
      4'd6:  o_out = i_in7;
      4'd7:  o_out = i_in8;
      4'd8:  o_out = i_in9;
      4'd9:  o_out = i_in10;
      4'd10: o_out = i_in11;
      4'd11: o_out = i_in12;
      4'd12: o_out = i_in13;
      4'd13: o_out = i_in14;
      4'd14: o_out = i_in15;
      4'd15: o_out = i_in16;
      default: o_out = i_in1;
    endcase
  end

endmodule : mux_16_1

// File: rtl/register_file.sv
// Register file with R0-R14 plus the PC as R15. Three read ports select
// a register (or pc+8 for R15) and latch it into output registers when
// lat_en is high; reads see the pre-write contents of the same edge.
module register_file
  import register_file_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   ra1,
  input  logic [3:0]   ra2,
  input  logic [3:0]   ra3,
  input  logic         lat_en,
  input  logic         we3,
  input  logic [3:0]   wa3,
  input  logic [W-1:0] wd3,
  input  logic         pc_we,
  input  logic [W-1:0] pc_next,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2,
  output logic [W-1:0] rd3,
  output logic [W-1:0] pc
);

  logic [W-1:0] r_regs [0:14];
  logic [W-1:0] r_pc;
  logic [W-1:0] r_rd [3];

  logic [W-1:0] w_pc_plus8;
  logic [3:0]   w_ra  [3];
  logic [W-1:0] w_sel [3];
  logic         w_wr_pc;

  assign w_pc_plus8 = r_pc + W'(PC_READ_OFFSET);
  assign w_ra[0]    = ra1;
  assign w_ra[1]    = ra2;
  assign w_ra[2]    = ra3;
  assign w_wr_pc    = we3 && (wa3 == PC_IDX);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_read_port
      mux_16_1 #(.W(W)) u_mux (
        .i_sel  (w_ra[gi]),
        .i_in1  (r_regs[0]),
        .i_in2  (r_regs[1]),
        .i_in3  (r_regs[2]),
        .i_in4  (r_regs[3]),
        .i_in5  (r_regs[4]),
        .i_in6  (r_regs[5]),
        .i_in7  (r_regs[6]),
        .i_in8  (r_regs[7]),
        .i_in9  (r_regs[8]),
        .i_in10 (r_regs[9]),
        .i_in11 (r_regs[10]),
        .i_in12 (r_regs[11]),
        .i_in13 (r_regs[12]),
        .i_in14 (r_regs[13]),
        .i_in15 (r_regs[14]),
        .i_in16 (w_pc_plus8),
        .o_out  (w_sel[gi])
      );
    end
  endgenerate

  // Storage, PC and read-operand latches; a register write to R15 takes
  // priority over pc_next, and latches capture pre-edge values (no bypass).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= '0;
      end
      r_pc <= '0;
      for (int p = 0; p < 3; p++) begin
        r_rd[p] <= '0;
      end
    end else begin
      if (we3 && (wa3 != PC_IDX)) begin
        r_regs[wa3] <= wd3;
      end
      if (w_wr_pc) begin
        r_pc <= wd3;
      end else if (pc_we) begin
        r_pc <= pc_next;
      end
      if (lat_en) begin
        for (int p = 0; p < 3; p++) begin
          r_rd[p] <= w_sel[p];
        end
      end
    end
  end

  assign rd1 = r_rd[0];
  assign rd2 = r_rd[1];
  assign rd3 = r_rd[2];
  assign pc  = r_pc;

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps for reset, write/read,
// hold, PC read, wrap and simultaneous write/PC update, then random traffic
// checked against a simple array model of the sixteen architectural registers.
module tb_register_file;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [3:0]   ra1, ra2, ra3;
  logic         lat_en;
  logic         we3;
  logic [3:0]   wa3;
  logic [W-1:0] wd3;
  logic         pc_we;
  logic [W-1:0] pc_next;
  logic [W-1:0] rd1, rd2, rd3, pc;

  int checks;
  int failures;

  // Model: index 0-14 general registers, index 15 is the PC.
  logic [W-1:0] m_reg [16];
  logic [W-1:0] m_rd  [3];

  register_file #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .ra1     (ra1),
    .ra2     (ra2),
    .ra3     (ra3),
    .lat_en  (lat_en),
    .we3     (we3),
    .wa3     (wa3),
    .wd3     (wd3),
    .pc_we   (pc_we),
    .pc_next (pc_next),
    .rd1     (rd1),
    .rd2     (rd2),
    .rd3     (rd3),
    .pc      (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_read(input logic [3:0] a);
    if (a == 4'd15) return m_reg[15] + 32'd8;
    return m_reg[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    for (int p = 0; p < 3; p++) m_rd[p] = '0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // One clock edge: model computes its next state from pre-edge values,
  // then outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic [W-1:0] n_rd [3];
    logic [W-1:0] n_pc;
    n_rd[0] = lat_en ? m_read(ra1) : m_rd[0];
    n_rd[1] = lat_en ? m_read(ra2) : m_rd[1];
    n_rd[2] = lat_en ? m_read(ra3) : m_rd[2];
    if (we3 && wa3 == 4'd15) n_pc = wd3;
    else if (pc_we)          n_pc = pc_next;
    else                     n_pc = m_reg[15];
    @(posedge clk);
    #1;
    if (we3 && wa3 != 4'd15) m_reg[wa3] = wd3;
    m_reg[15] = n_pc;
    for (int p = 0; p < 3; p++) m_rd[p] = n_rd[p];
  endtask

  task automatic idle_inputs();
    lat_en = 1'b0; we3 = 1'b0; pc_we = 1'b0;
    wa3 = '0; wd3 = '0; pc_next = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_clear();
    reset = 1'b1;
    ra1 = '0; ra2 = '0; ra3 = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_rd1", rd1, 32'h0);
    reset = 1'b0;

    // Write/read R3.
    we3 = 1'b1; wa3 = 4'd3; wd3 = 32'hDEADBEEF;
    tick();
    idle_inputs(); ra1 = 4'd3; lat_en = 1'b1;
    tick();
    check("wr_rd_r3", rd1, 32'hDEADBEEF);

    // Hold while R3 is overwritten.
    idle_inputs(); we3 = 1'b1; wa3 = 4'd3; wd3 = 32'h1;
    tick();
    check("hold_rd1", rd1, 32'hDEADBEEF);

    // PC update then read R15.
    idle_inputs(); pc_we = 1'b1; pc_next = 32'h100;
    tick();
    check("pc_load", pc, 32'h100);
    idle_inputs(); ra2 = 4'd15; lat_en = 1'b1;
    tick();
    check("pc_read_rd2", rd2, 32'h108);

    // Register write to R15 beats pc_next; latch sees old pc+8.
    idle_inputs();
    we3 = 1'b1; wa3 = 4'd15; wd3 = 32'h200; pc_we = 1'b1; pc_next = 32'h300;
    ra1 = 4'd15; lat_en = 1'b1;
    tick();
    check("simul_pc", pc, 32'h200);
    check("simul_rd1", rd1, 32'h108);

    // pc+8 wraps.
    idle_inputs(); pc_we = 1'b1; pc_next = 32'hFFFFFFFC;
    tick();
    idle_inputs(); ra3 = 4'd15; lat_en = 1'b1;
    tick();
    check("wrap_rd3", rd3, 32'h4);

    // No bypass: writing R5 while latching R5 captures the old value.
    idle_inputs(); we3 = 1'b1; wa3 = 4'd5; wd3 = 32'hA5A5_0055;
    ra1 = 4'd5; ra2 = 4'd5; ra3 = 4'd5; lat_en = 1'b1;
    tick();
    check("nobypass_rd1", rd1, 32'h0);
    idle_inputs(); lat_en = 1'b1;
    tick();
    check("same_addr_rd1", rd1, 32'hA5A5_0055);
    check("same_addr_rd2", rd2, 32'hA5A5_0055);
    check("same_addr_rd3", rd3, 32'hA5A5_0055);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      ra1    = 4'($urandom_range(0, 15));
      ra2    = 4'($urandom_range(0, 15));
      ra3    = 4'($urandom_range(0, 15));
      lat_en = 1'($urandom_range(0, 1));
      we3    = ($urandom_range(0, 3) != 0);
      wa3    = 4'($urandom_range(0, 15));
      wd3    = $urandom;
      pc_we  = 1'($urandom_range(0, 1));
      pc_next = $urandom;
      tick();
      check("rand_rd1", rd1, m_rd[0]);
      check("rand_rd2", rd2, m_rd[1]);
      check("rand_rd3", rd3, m_rd[2]);
      check("rand_pc", pc, m_reg[15]);
    end

    // Mid-cycle reset with a pending write: outputs clear immediately.
    idle_inputs(); we3 = 1'b1; wa3 = 4'd2; wd3 = 32'h1234_5678;
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_rd1", rd1, 32'h0);
    check("async_rst_rd2", rd2, 32'h0);
    check("async_rst_rd3", rd3, 32'h0);
    check("async_rst_pc", pc, 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs(); ra1 = 4'd15; ra2 = 4'd2; lat_en = 1'b1;
    tick();
    check("post_rst_r15", rd1, 32'h8);
    check("post_rst_r2", rd2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have parameter W, default 32, giving the data and PC width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ra1, ra2, ra3  input  4 each  read addresses for Rn, Rm and Rs.
REQ-005 lat_en  input  1  latch enable for the read-operand registers.
REQ-006 we3  input  1  register write enable.
REQ-007 wa3  input  4  write address.
REQ-008 wd3  input  W  write data.
REQ-009 pc_we  input  1  PC update enable.
REQ-010 pc_next  input  W  next PC value.
REQ-011 rd1, rd2, rd3  output  W each  registered read operands.
REQ-012 pc  output  W  current program counter (R15).

Function
REQ-013 Storage SHALL be registers R0-R14 (W bits each) plus the PC register as R15.
REQ-014 Each read port SHALL combinationally select R[ra] for ra 0-14.
REQ-015 Each read port SHALL select pc+8 for ra=15.
REQ-016 The pc+8 sum SHALL wrap modulo 2^W.
REQ-017 On each rising edge with lat_en=1, rd1/rd2/rd3 SHALL load their selected values, giving a 1-cycle read latency.
REQ-018 With lat_en=0, rd1/rd2/rd3 SHALL hold their values.
REQ-019 On each rising edge with we3=1 and wa3 in 0-14, R[wa3] SHALL take wd3.
REQ-020 On each rising edge with we3=1 and wa3=15, pc SHALL take wd3.
REQ-021 If REQ-020 applies while pc_we=1, wd3 SHALL win over pc_next.
REQ-022 On each rising edge with pc_we=1 and no write to R15, pc SHALL take pc_next.
REQ-023 On a rising edge with lat_en=1 and a write to an address being read, the latch SHALL capture the pre-write contents (no bypass).
REQ-024 On a rising edge with lat_en=1 and a pc update while a port reads R15, the latch SHALL capture old pc+8.
REQ-025 Two or three ports with the same address SHALL return identical values.
REQ-026 we3=0 SHALL leave R0-R14 unchanged.
REQ-027 we3=0 and pc_we=0 SHALL leave pc unchanged.
REQ-028 All outputs SHALL be driven only from registers, with no combinational path from inputs to outputs.

Reset
REQ-029 While reset=1, R0-R14, pc, rd1, rd2 and rd3 SHALL be 0, asynchronously and independent of clk.
REQ-030 Reset asserted mid-write SHALL discard the write, with no partial update.
REQ-031 At the first rising edge after reset deasserts, normal operation SHALL resume, and a read of R15 SHALL then latch 8.

Structure
REQ-032 A shared package SHALL hold constants PC_IDX=4'd15 and PC_READ_OFFSET=8 and the default width 32.
REQ-033 Each read port SHALL be an instance of sub-module mux_16_1 (W-bit, 16:1, select = read address), with in16 = pc+8.
REQ-034 The storage and latch logic SHALL be in a single always block sensitive to posedge clk and posedge reset.

Verification
REQ-035 Reset: assert reset mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
REQ-036 Write/read: we3=1, wa3=3, wd3=0xDEADBEEF, then ra1=3 with lat_en=1 -> rd1=0xDEADBEEF one cycle later.
REQ-037 Hold: after REQ-036, lat_en=0 and a write of 0x1 to R3 -> rd1 stays 0xDEADBEEF.
REQ-038 PC read: pc_we=1 with pc_next=0x100, then ra2=15 with lat_en=1 -> rd2=0x108.
REQ-039 Wrap: pc_next=0xFFFFFFFC, then ra3=15 latched -> rd3=0x00000004.
REQ-040 Simultaneous events: same edge has we3=1, wa3=15, wd3=0x200, pc_we=1, pc_next=0x300, and ra1=15 latched with old pc=0x100 -> pc=0x200 and rd1=0x108.
